// File: rtl/speck_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// speck_pkg : shared constants, state encoding and rotate helpers, SPECK32/64
// Revision  : 1.0
// ---------------------------------------------------------------------------
package speck_pkg;

   localparam int WORD   = 16;
   localparam int ROUNDS = 22;
   localparam int ALPHA  = 7;
   localparam int BETA   = 2;
   localparam int IDX_W  = 5;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_EXPAND = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   function automatic logic [WORD-1:0] ror(input logic [WORD-1:0] x, input int unsigned amt);
      return (x >> amt) | (x << (WORD - amt));
   endfunction

   function automatic logic [WORD-1:0] rol(input logic [WORD-1:0] x, input int unsigned amt);
      return (x << amt) | (x >> (WORD - amt));
   endfunction

endpackage
`default_nettype wire

// File: rtl/speck_ks_step.sv
`default_nettype none
// ---------------------------------------------------------------------------
// speck_ks_step : one combinational key-schedule round (l_new, k_next)
// Revision      : 1.0
// ---------------------------------------------------------------------------
module speck_ks_step #(
   parameter int ALPHA = speck_pkg::ALPHA,
   parameter int BETA  = speck_pkg::BETA
) (
   input  logic [speck_pkg::WORD-1:0]  k,
   input  logic [speck_pkg::WORD-1:0]  l0,
   input  logic [speck_pkg::IDX_W-1:0] i,
   output logic [speck_pkg::WORD-1:0]  l_new,
   output logic [speck_pkg::WORD-1:0]  k_next
);

   localparam int unsigned ALPHA_U = ALPHA;
   localparam int unsigned BETA_U  = BETA;

   // Round index is zero-extended before mixing into the word.
   always_comb begin
      l_new  = (k + speck_pkg::ror(l0, ALPHA_U)) ^ {{(speck_pkg::WORD-speck_pkg::IDX_W){1'b0}}, i};
      k_next = speck_pkg::rol(k, BETA_U) ^ l_new;
   end

endmodule
`default_nettype wire

// File: rtl/speck_key_schedule.sv
`default_nettype none
// ---------------------------------------------------------------------------
// speck_key_schedule : streaming SPECK32/64 round-key expander with key buffer
// Revision           : 1.0
// ---------------------------------------------------------------------------
module speck_key_schedule #(
   parameter int ROUNDS = speck_pkg::ROUNDS,
   parameter int ALPHA  = speck_pkg::ALPHA,
   parameter int BETA   = speck_pkg::BETA
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          key_valid,
   output logic                          key_ready,
   input  logic [63:0]                   key,
   output logic                          rk_valid,
   input  logic                          rk_ready,
   output logic [speck_pkg::WORD-1:0]    rk_data,
   output logic [speck_pkg::IDX_W-1:0]   rk_index,
   output logic                          done,
   input  logic [speck_pkg::IDX_W-1:0]   rd_addr,
   output logic [speck_pkg::WORD-1:0]    rd_data
);

   localparam int WORD  = speck_pkg::WORD;
   localparam int IDX_W = speck_pkg::IDX_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

   speck_pkg::state_t state;
   logic [WORD-1:0]   k, l0, l1, l2;
   logic [IDX_W-1:0]  idx;
   logic [WORD-1:0]   l_new, k_next;
   logic              advance;
   logic [WORD-1:0]   buffer [ROUNDS];

   speck_ks_step #(
      .ALPHA (ALPHA),
      .BETA  (BETA)
   ) u_step (
      .k      (k),
      .l0     (l0),
      .i      (idx),
      .l_new  (l_new),
      .k_next (k_next)
   );

   assign rk_valid  = (state == speck_pkg::S_EXPAND);
   assign key_ready = (state != speck_pkg::S_EXPAND);
   assign rk_data   = k;
   assign rk_index  = idx;
   assign advance   = rk_valid && rk_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= speck_pkg::S_IDLE;
         k     <= '0;
         l0    <= '0;
         l1    <= '0;
         l2    <= '0;
         idx   <= '0;
         done  <= 1'b0;
      end else begin
         case (state)
            speck_pkg::S_IDLE, speck_pkg::S_DONE: begin
               if (key_valid) begin
                  k     <= key[15:0];
                  l0    <= key[31:16];
                  l1    <= key[47:32];
                  l2    <= key[63:48];
                  idx   <= '0;
                  done  <= 1'b0;
                  state <= speck_pkg::S_EXPAND;
               end
            end
            speck_pkg::S_EXPAND: begin
               if (rk_ready) begin
                  k  <= k_next;
                  l0 <= l1;
                  l1 <= l2;
                  l2 <= l_new;
                  // idx stays on the last entry so rk_index is steady in DONE.
                  if (idx == LAST_IDX) begin
                     state <= speck_pkg::S_DONE;
                     done  <= 1'b1;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            default: state <= speck_pkg::S_IDLE;
         endcase
      end
   end

   // Buffer is intentionally not reset; done qualifies its contents.
   always_ff @(posedge clk) begin
      if (!rst && advance) begin
         buffer[idx] <= k;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data <= '0;
      end else if (rd_addr <= LAST_IDX) begin
         rd_data <= buffer[rd_addr];
      end else begin
         rd_data <= '0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_speck_key_schedule.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_speck_key_schedule : scoreboard bench for speck_key_schedule
// Revision              : 1.0
// ---------------------------------------------------------------------------
module tb_speck_key_schedule;

   localparam int NR = 22;
   localparam logic [63:0] KEY_A = 64'h1918_1110_0908_0100;
   localparam logic [63:0] KEY_B = 64'h0123_4567_89AB_CDEF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        key_valid = 1'b0;
   logic        key_ready;
   logic [63:0] key = '0;
   logic        rk_valid;
   logic        rk_ready = 1'b0;
   logic [15:0] rk_data;
   logic [4:0]  rk_index;
   logic        done;
   logic [4:0]  rd_addr = '0;
   logic [15:0] rd_data;

   int checks   = 0;
   int failures = 0;

   logic [20:0] sb [$];
   logic [15:0] exp_keys [NR];

   speck_key_schedule dut (
      .clk       (clk),
      .rst       (rst),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .key       (key),
      .rk_valid  (rk_valid),
      .rk_ready  (rk_ready),
      .rk_data   (rk_data),
      .rk_index  (rk_index),
      .done      (done),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Reference model: rotations written as explicit bit concatenations.
   task automatic build_expected(input logic [63:0] mk);
      logic [15:0] kk, ln;
      logic [15:0] l [3];
      kk   = mk[15:0];
      l[0] = mk[31:16];
      l[1] = mk[47:32];
      l[2] = mk[63:48];
      sb.delete();
      for (int i = 0; i < NR; i++) begin
         exp_keys[i] = kk;
         sb.push_back({5'(i), kk});
         ln   = (kk + {l[0][6:0], l[0][15:7]}) ^ 16'(i);
         kk   = {kk[13:0], kk[15:14]} ^ ln;
         l[0] = l[1];
         l[1] = l[2];
         l[2] = ln;
      end
   endtask

   task automatic load_key(input logic [63:0] mk);
      chk("key_ready_before_load", {63'd0, key_ready}, 64'd1);
      key       = mk;
      key_valid = 1'b1;
      build_expected(mk);
      tick();
      key_valid = 1'b0;
      chk("rk_valid_after_load", {63'd0, rk_valid}, 64'd1);
      chk("done_low_after_load", {63'd0, done}, 64'd0);
      chk("key_ready_in_expand", {63'd0, key_ready}, 64'd0);
   endtask

   // mode 0: ready held high; mode 1: random ready. pulse_at/abort_at = -1 disables.
   task automatic run_expand(input int mode, input int pulse_at, input int abort_at);
      int          cycles;
      logic        stalled;
      logic [15:0] prev_data;
      logic [4:0]  prev_idx;
      logic [20:0] e;
      cycles  = 0;
      stalled = 1'b0;
      while (sb.size() > 0 && cycles < 400) begin
         if (!rk_valid) begin
            chk("rk_valid_dropped_early", {63'd0, rk_valid}, 64'd1);
            break;
         end
         if (stalled) begin
            chk("stall_rk_data", {48'd0, rk_data}, {48'd0, prev_data});
            chk("stall_rk_index", {59'd0, rk_index}, {59'd0, prev_idx});
         end
         if (abort_at >= 0 && int'(rk_index) == abort_at) begin
            rst      = 1'b1;
            rk_ready = 1'b1;
            tick();
            rst = 1'b0;
            sb.delete();
            return;
         end
         rk_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         if (pulse_at >= 0 && int'(rk_index) == pulse_at) begin
            key       = KEY_B;
            key_valid = 1'b1;
         end
         if (rk_ready) begin
            e = sb.pop_front();
            chk("rk_data", {48'd0, rk_data}, {48'd0, e[15:0]});
            chk("rk_index", {59'd0, rk_index}, {59'd0, e[20:16]});
         end
         stalled   = !rk_ready;
         prev_data = rk_data;
         prev_idx  = rk_index;
         tick();
         key_valid = 1'b0;
         cycles++;
      end
      rk_ready = 1'b0;
      chk("all_keys_emitted", 64'(sb.size()), 64'd0);
      if (mode == 0) chk("throughput_cycles", 64'(cycles), 64'(NR));
      chk("done_after_expand", {63'd0, done}, 64'd1);
      chk("rk_valid_in_done", {63'd0, rk_valid}, 64'd0);
      chk("key_ready_in_done", {63'd0, key_ready}, 64'd1);
   endtask

   task automatic read_all();
      for (int a = 0; a < NR; a++) begin
         rd_addr = 5'(a);
         tick();
         chk("rd_data_entry", {48'd0, rd_data}, {48'd0, exp_keys[a]});
      end
   endtask

   initial begin
      @(negedge clk);
      tick();
      tick();
      chk("reset_key_ready", {63'd0, key_ready}, 64'd1);
      chk("reset_rk_valid", {63'd0, rk_valid}, 64'd0);
      chk("reset_rk_data", {48'd0, rk_data}, 64'd0);
      chk("reset_rk_index", {59'd0, rk_index}, 64'd0);
      chk("reset_done", {63'd0, done}, 64'd0);
      chk("reset_rd_data", {48'd0, rd_data}, 64'd0);
      rst = 1'b0;
      tick();

      // Known-answer load with continuous ready
      load_key(KEY_A);
      chk("first_key_k0", {48'd0, rk_data}, 64'h0100);
      chk("first_key_idx", {59'd0, rk_index}, 64'd0);
      run_expand(0, -1, -1);

      rd_addr = 5'd1;
      tick();
      chk("rd_addr1_kat", {48'd0, rd_data}, 64'h1512);
      rd_addr = 5'd22;
      tick();
      chk("rd_addr22_zero", {48'd0, rd_data}, 64'h0000);
      rd_addr = 5'd31;
      tick();
      chk("rd_addr31_zero", {48'd0, rd_data}, 64'h0000);
      read_all();

      // Same key with random backpressure
      load_key(KEY_A);
      run_expand(1, -1, -1);

      // Second key from DONE overwrites the buffer
      load_key(KEY_B);
      run_expand(1, -1, -1);
      read_all();

      // key_valid pulse during expansion is ignored
      load_key(KEY_A);
      run_expand(0, 5, -1);
      read_all();

      // Reset mid-expansion aborts
      load_key(KEY_A);
      run_expand(0, -1, 10);
      chk("abort_rk_valid", {63'd0, rk_valid}, 64'd0);
      chk("abort_key_ready", {63'd0, key_ready}, 64'd1);
      chk("abort_done", {63'd0, done}, 64'd0);
      rk_ready = 1'b1;
      tick();
      tick();
      chk("abort_still_idle", {63'd0, rk_valid}, 64'd0);
      rk_ready = 1'b0;
      load_key(KEY_A);
      chk("reload_k0", {48'd0, rk_data}, 64'h0100);
      chk("reload_idx", {59'd0, rk_index}, 64'd0);
      run_expand(1, -1, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/speck_key_schedule.md
SPECK_KEY_SCHEDULE -- requirements
Module: speck_key_schedule

Interface
REQ-001 Parameter ROUNDS, default 22, SHALL set the number of round keys produced (SPECK32/64).
REQ-002 Parameter ALPHA, default 7, SHALL set the right-rotate amount applied to l words.
REQ-003 Parameter BETA, default 2, SHALL set the left-rotate amount applied to k words.
REQ-004 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1, SHALL be the synchronous, active-high reset.
REQ-006 Port key_valid, input, 1, SHALL indicate that key holds a master key.
REQ-007 Port key_ready, output, 1, SHALL indicate that a key can be accepted.
REQ-008 Port key, input, 64, SHALL carry {l2,l1,l0,k0}, with k0 in bits 15:0.
REQ-009 Port rk_valid, output, 1, SHALL indicate that rk_data/rk_index hold a round key.
REQ-010 Port rk_ready, input, 1, SHALL be the downstream (round XOR stage) acceptance.
REQ-011 Port rk_data, output, 16, SHALL carry round key k[i].
REQ-012 Port rk_index, output, 5, SHALL carry i, from 0 to ROUNDS-1.
REQ-013 Port done, output, 1, SHALL indicate that all ROUNDS keys are stored.
REQ-014 Port rd_addr, input, 5, SHALL be the stored-key read address.
REQ-015 Port rd_data, output, 16, SHALL return the stored key k[rd_addr].

Function
REQ-016 The block SHALL have the states IDLE, EXPAND and DONE.
REQ-017 key_ready SHALL be 1 in IDLE and DONE, and 0 in EXPAND.
REQ-018 A key SHALL be accepted when key_valid && key_ready; the block SHALL load k=k0, l shift register={l2,l1,l0}, set i=0, clear done, and enter EXPAND.
REQ-019 The first rk_valid SHALL occur in the cycle after acceptance, with rk_data=k0 and rk_index=0.
REQ-020 In EXPAND, rk_valid SHALL be 1; a handshake (rk_valid && rk_ready) SHALL store k[i] to buffer entry i and advance i.
REQ-021 Each advance SHALL compute l_new=(k + ROR(l0,ALPHA)) xor i and k_next=ROL(k,BETA) xor l_new, all mod 2^16, and then shift l as l0<-l1, l1<-l2, l2<-l_new.
REQ-022 With rk_ready held at 1, throughput SHALL be one key per cycle, and ROUNDS keys SHALL be produced in ROUNDS consecutive cycles.
REQ-023 While rk_valid && !rk_ready, rk_data, rk_index and all internal state SHALL be held stable.
REQ-024 The handshake at i=ROUNDS-1 SHALL move the block to DONE; done SHALL be 1 and rk_valid SHALL be 0 from the next cycle.
REQ-025 key_valid during EXPAND SHALL be ignored, with no state change.
REQ-026 A key accepted in DONE SHALL restart expansion: done falls in the next cycle, and the buffer is overwritten entry by entry.
REQ-027 rd_data SHALL have a registered, 1-cycle latency and SHALL be valid in any state for entries already written.
REQ-028 rd_addr >= ROUNDS SHALL return 0x0000.

Reset
REQ-029 rst SHALL put the block in IDLE with key_ready=1, rk_valid=0, rk_data=0, rk_index=0, done=0 and rd_data=0.
REQ-030 rst asserted mid-EXPAND SHALL abort the expansion; no further keys SHALL be emitted until a new key is accepted.
REQ-031 Buffer contents need not be cleared by rst; done=0 marks them invalid.

Structure
REQ-032 A shared package speck_pkg SHALL hold WORD=16, ROUNDS=22, ALPHA=7, BETA=2 and the state enum.
REQ-033 One combinational sub-module, speck_ks_step, SHALL implement REQ-021 (inputs k, l0, i; outputs l_new, k_next).
REQ-034 The buffer SHALL be a register array of ROUNDS x 16 bits; no RAM macro SHALL be inferred.

Verification
REQ-035 Load key=0x1918_1110_0908_0100 with rk_ready=1 -> first key k0=0x0100 at index 0, second key k1=0x1512 at index 1, done after 22 keys; all 22 keys SHALL match the bench reference model.
REQ-036 Same key with rk_ready toggled randomly (50%) -> identical key sequence, no drops or duplicates, and rk_data stable during stalls.
REQ-037 key_valid pulsed at index 5 during EXPAND -> no effect, and the sequence continues unchanged.
REQ-038 rst asserted at index 10 -> next cycle rk_valid=0, key_ready=1, done=0; a reloaded key restarts at index 0 with k0=0x0100.
REQ-039 After done: rd_addr=1 -> rd_data=0x1512 one cycle later; rd_addr=22 -> 0x0000.
REQ-040 In DONE, load a second key -> done falls in the next cycle, and the new sequence overwrites the buffer and matches the reference model.
